// File: rtl/note_sequencer.sv
// note_sequencer: bus-fed FIFO of packed {freq,dur} notes, played back to back into the buzzer
// stage with tick-accurate durations, a programmable inter-note gap and a queue-drained interrupt.
module note_sequencer #(
  parameter int DEPTH       = 16,
  parameter int CLK_TICK    = 400000,
  parameter int GAP_DEFAULT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [15:0] freq_o,
  output logic        gate_o,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = 48;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          enable;
  logic          irq_en;
  logic          done;
  logic          overflow;
  logic [15:0]   gap_reg;

  logic          wr_note;
  logic          wr_status;
  logic          wr_ctrl;
  logic          wr_gap;
  logic          flush;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          timer_done;
  logic          note_end;
  logic          done_set;
  logic [31:0]   head;
  logic [31:0]   status;
  logic [TW-1:0] dur_cycles;
  logic [TW-1:0] gap_cycles;
  logic          unused_bits;

  assign wr_note   = cs_i && write_i && (address_i[3:2] == 2'd0);
  assign wr_status = cs_i && write_i && (address_i[3:2] == 2'd1);
  assign wr_ctrl   = cs_i && write_i && (address_i[3:2] == 2'd2);
  assign wr_gap    = cs_i && write_i && (address_i[3:2] == 2'd3);
  assign flush     = wr_ctrl && data_in[1];

  // Full is judged on the pre-pop count so a push racing a pop while full is still dropped.
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_note && !full && !flush;
  assign pop   = (state == S_IDLE) && enable && !empty && !flush;
  assign head  = mem[rd_ptr];

  // Wide products so the longest note (0xFFFF ticks) never truncates.
  assign dur_cycles = TW'(head[15:0]) * TW'(CLK_TICK) - TW'(1);
  assign gap_cycles = TW'(gap_reg) * TW'(CLK_TICK) - TW'(1);
  assign timer_done = (timer == '0);
  assign note_end   = ((state == S_PLAY) && timer_done && (gap_reg == 16'd0)) ||
                      ((state == S_GAP) && timer_done);
  assign done_set   = note_end && empty && !flush;

  assign status = {19'b0, empty, full, (state != S_IDLE), overflow, done, 8'(count)};
  assign unused_bits = ^{read_i, address_i[31:4], address_i[1:0]};

  always_comb begin
    data_out = '0;
    case (address_i[3:2])
      2'd0:    data_out = empty ? 32'd0 : head;
      2'd1:    data_out = status;
      2'd2:    data_out = {29'b0, irq_en, 1'b0, enable};
      default: data_out = {16'b0, gap_reg};
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      gap_reg  <= 16'(GAP_DEFAULT);
      overflow <= 1'b0;
      done     <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= data_in[0];
        irq_en <= data_in[2];
      end
      if (wr_gap) gap_reg <= data_in[15:0];
      if (flush) overflow <= 1'b0;
      else if (wr_note && full) overflow <= 1'b1;
      if (done_set) done <= 1'b1;
      else if (wr_status && data_in[8]) done <= 1'b0;
      irq_o <= done & irq_en;
    end
  end

  // A zero-duration entry is popped and dropped without touching the outputs or starting a gap.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state  <= S_IDLE;
      timer  <= '0;
      freq_o <= 16'd0;
      gate_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop && (head[15:0] != 16'd0)) begin
            state  <= S_PLAY;
            timer  <= dur_cycles;
            freq_o <= head[31:16];
            gate_o <= (head[31:16] != 16'd0);
          end
        end
        S_PLAY: begin
          if (timer_done) begin
            gate_o <= 1'b0;
            if (gap_reg != 16'd0) begin
              state <= S_GAP;
              timer <= gap_cycles;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_GAP: begin
          if (timer_done) state <= S_IDLE;
          else timer <= timer - TW'(1);
        end
        default: begin
          state  <= S_IDLE;
          gate_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: register vector table plus timed playback sequences.
module tb_note_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs_i;
  logic        read_i;
  logic        write_i;
  logic [31:0] address_i;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [15:0] freq_o;
  logic        gate_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(16), .CLK_TICK(4), .GAP_DEFAULT(1)) dut (
    .clk(clk), .reset(reset), .cs_i(cs_i), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .data_in(data_in), .data_out(data_out),
    .freq_o(freq_o), .gate_o(gate_o), .irq_o(irq_o)
  );

  typedef struct {
    bit          do_write;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] exp_rd;
    string       name;
  } reg_vec_t;

  reg_vec_t vecs[16];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    cs_i = 1'b1; write_i = 1'b1; address_i = addr; data_in = data;
    @(negedge clk);
    cs_i = 1'b0; write_i = 1'b0; address_i = 32'h4; data_in = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    cs_i = 1'b1; read_i = 1'b1; address_i = addr;
    #1;
    data = data_out;
    cs_i = 1'b0; read_i = 1'b0; address_i = 32'h4;
  endtask

  task automatic apply_stimulus(input reg_vec_t v);
    logic [31:0] d;
    if (v.do_write) bus_write(v.wr_addr, v.wdata);
    bus_read(v.rd_addr, d);
    check_output(v.name, d, v.exp_rd);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gate_high(input string name);
    int n = 0;
    while (gate_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output(name, {31'b0, gate_o}, 32'd1);
  endtask

  // Latency to gate rise, captured frequency, gate-high cycles, then busy cycles with gate low.
  task automatic play_note(output int lat, output logic [15:0] f, output int high, output int gapc);
    lat = 0;
    while (gate_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    f = freq_o;
    high = 0;
    while (gate_o === 1'b1 && high < 1000) begin
      high++;
      @(negedge clk);
    end
    gapc = 0;
    while (gate_o === 1'b0 && data_out[10] === 1'b1 && gapc < 1000) begin
      gapc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, high, gapc;
    logic [15:0] f;
    logic [31:0] act_trace, exp_trace;
    bit care;

    vecs[0]  = '{1'b0, 32'h0, 32'h0,         32'h4, 32'h0000_1000, "status_rst"};
    vecs[1]  = '{1'b0, 32'h0, 32'h0,         32'hC, 32'h0000_0001, "gap_rst"};
    vecs[2]  = '{1'b0, 32'h0, 32'h0,         32'h8, 32'h0000_0000, "ctrl_rst"};
    vecs[3]  = '{1'b0, 32'h0, 32'h0,         32'h0, 32'h0000_0000, "note_empty"};
    vecs[4]  = '{1'b1, 32'hC, 32'h0000_0003, 32'hC, 32'h0000_0003, "gap_wr"};
    vecs[5]  = '{1'b1, 32'hC, 32'hFFFF_0002, 32'hC, 32'h0000_0002, "gap_hi_bits"};
    vecs[6]  = '{1'b1, 32'h8, 32'h0000_0004, 32'h8, 32'h0000_0004, "ctrl_irqen"};
    vecs[7]  = '{1'b1, 32'h0, 32'h1234_0005, 32'h0, 32'h1234_0005, "note_head"};
    vecs[8]  = '{1'b0, 32'h0, 32'h0,         32'h4, 32'h0000_0001, "status_cnt1"};
    vecs[9]  = '{1'b1, 32'h0, 32'hABCD_0001, 32'h0, 32'h1234_0005, "note_head_keep"};
    vecs[10] = '{1'b0, 32'h0, 32'h0,         32'h4, 32'h0000_0002, "status_cnt2"};
    vecs[11] = '{1'b1, 32'h8, 32'h0000_0006, 32'h8, 32'h0000_0004, "ctrl_flush_rd0"};
    vecs[12] = '{1'b0, 32'h0, 32'h0,         32'h4, 32'h0000_1000, "status_flushed"};
    vecs[13] = '{1'b0, 32'h0, 32'h0,         32'h0, 32'h0000_0000, "note_flushed"};
    vecs[14] = '{1'b1, 32'hC, 32'h0000_0001, 32'hC, 32'h0000_0001, "gap_restore"};
    vecs[15] = '{1'b1, 32'h8, 32'h0000_0000, 32'h8, 32'h0000_0000, "ctrl_clear"};

    reset = 1'b0; cs_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
    address_i = 32'h4; data_in = 32'd0;
    wait_cycles(2);
    check_output("rst_freq", {16'b0, freq_o}, 32'd0);
    check_output("rst_gate", {31'b0, gate_o}, 32'd0);
    check_output("rst_irq",  {31'b0, irq_o},  32'd0);
    reset = 1'b1;

    $display("[TB] register vectors");
    for (int i = 0; i < 16; i++) apply_stimulus(vecs[i]);

    $display("[TB] single note with irq");
    bus_write(32'h8, 32'h5);
    bus_write(32'h0, 32'h0064_0003);
    play_note(lat, f, high, gapc);
    check_output("n1_latency", 32'(lat), 32'd1);
    check_output("n1_freq", {16'b0, f}, 32'h0064);
    check_output("n1_high", 32'(high), 32'd12);
    check_output("n1_gap", 32'(gapc), 32'd4);
    bus_read(32'h4, rd);
    check_output("n1_status_done", rd, 32'h0000_1100);
    wait_cycles(1);
    check_output("n1_irq_set", {31'b0, irq_o}, 32'd1);
    bus_write(32'h4, 32'h100);
    wait_cycles(1);
    check_output("n1_irq_clr", {31'b0, irq_o}, 32'd0);
    bus_read(32'h4, rd);
    check_output("n1_status_clr", rd, 32'h0000_1000);

    $display("[TB] fill to overflow and drain");
    bus_write(32'h8, 32'h0);
    for (int i = 0; i < 17; i++) bus_write(32'h0, {16'(16 + i), 16'd1});
    bus_read(32'h4, rd);
    check_output("fill_status", rd, 32'h0000_0A10);
    bus_read(32'h0, rd);
    check_output("fill_head", rd, 32'h0010_0001);
    bus_write(32'h8, 32'h1);
    for (int i = 0; i < 16; i++) begin
      play_note(lat, f, high, gapc);
      check_output($sformatf("drain_lat_%0d", i), 32'(lat), 32'd1);
      check_output($sformatf("drain_freq_%0d", i), {16'b0, f}, 32'(16 + i));
      check_output($sformatf("drain_high_%0d", i), 32'(high), 32'd4);
      check_output($sformatf("drain_gap_%0d", i), 32'(gapc), 32'd4);
    end
    bus_read(32'h4, rd);
    check_output("drain_status", rd, 32'h0000_1300);
    wait_cycles(10);
    check_output("drain_no_extra", {31'b0, gate_o}, 32'd0);
    bus_write(32'h8, 32'h2);
    bus_read(32'h4, rd);
    check_output("drain_ovf_clr", rd, 32'h0000_1100);
    bus_write(32'h4, 32'h100);
    bus_read(32'h4, rd);
    check_output("drain_done_clr", rd, 32'h0000_1000);

    $display("[TB] rest, zero-duration skip, short note");
    bus_write(32'h0, 32'h0000_0002);
    bus_write(32'h0, 32'h00C8_0000);
    bus_write(32'h0, 32'h0032_0001);
    bus_write(32'h8, 32'h1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) check_output("rest_count", {24'b0, data_out[7:0]}, 32'd2);
      care = !((k == 13) || (k == 14) || (k >= 23));
      act_trace = {14'b0, data_out[10], gate_o, care ? freq_o : 16'h0};
      if (k <= 12)      exp_trace = {14'b0, 1'b1, 1'b0, 16'h0000};
      else if (k <= 14) exp_trace = {14'b0, 1'b0, 1'b0, 16'h0000};
      else if (k <= 18) exp_trace = {14'b0, 1'b1, 1'b1, 16'h0032};
      else if (k <= 22) exp_trace = {14'b0, 1'b1, 1'b0, 16'h0032};
      else              exp_trace = {14'b0, 1'b0, 1'b0, 16'h0000};
      check_output($sformatf("rest_trace_%0d", k), act_trace, exp_trace);
    end
    bus_read(32'h4, rd);
    check_output("rest_status", rd, 32'h0000_1100);
    bus_write(32'h4, 32'h100);

    $display("[TB] flush mid-note");
    bus_write(32'h8, 32'h0);
    for (int i = 0; i < 17; i++) bus_write(32'h0, {16'(32'h100 + i), 16'd4});
    bus_read(32'h4, rd);
    check_output("fl_fill_status", rd, 32'h0000_0A10);
    bus_write(32'h8, 32'h1);
    wait_gate_high("fl_gate_rise");
    wait_cycles(3);
    check_output("fl_gate_mid", {31'b0, gate_o}, 32'd1);
    bus_write(32'h8, 32'h2);
    check_output("fl_gate", {31'b0, gate_o}, 32'd0);
    check_output("fl_freq", {16'b0, freq_o}, 32'd0);
    bus_read(32'h4, rd);
    check_output("fl_status", rd, 32'h0000_1000);
    wait_cycles(20);
    check_output("fl_gate_later", {31'b0, gate_o}, 32'd0);
    bus_read(32'h4, rd);
    check_output("fl_status_later", rd, 32'h0000_1000);

    $display("[TB] reset mid-note");
    bus_write(32'hC, 32'h3);
    bus_write(32'h8, 32'h5);
    bus_write(32'h0, 32'h0064_0005);
    wait_gate_high("rs_gate_rise");
    wait_cycles(2);
    reset = 1'b0;
    @(negedge clk);
    check_output("rs_freq", {16'b0, freq_o}, 32'd0);
    check_output("rs_gate", {31'b0, gate_o}, 32'd0);
    check_output("rs_irq",  {31'b0, irq_o},  32'd0);
    reset = 1'b1;
    bus_read(32'h4, rd);
    check_output("rs_status", rd, 32'h0000_1000);
    bus_read(32'h8, rd);
    check_output("rs_ctrl", rd, 32'h0000_0000);
    bus_read(32'hC, rd);
    check_output("rs_gap", rd, 32'h0000_0001);
    wait_cycles(5);
    check_output("rs_gate_later", {31'b0, gate_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
